// File: rtl/approx_div_8x4.sv
// approx_div_8x4: sequential radix-2 restoring divider, 8-bit dividend / 4-bit divisor.
// One quotient bit per clock, valid/ready handshakes on both sides.
// Optional feature: define DIV_ROUND_EN for a round-half-up quotient (remainder stays unrounded).
// A zero divisor spends a single cycle in CALC, so its result appears one cycle after accept.
module approx_div_8x4 #(
    parameter int unsigned DIVIDEND_W = 8,
    parameter int unsigned DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int unsigned CNT_W  = $clog2(DIVIDEND_W + 1);
    localparam int unsigned PART_W = DIVISOR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CNT_W-1:0]      cnt;
    logic [DIVIDEND_W-1:0] dvd;
    logic [DIVISOR_W-1:0]  dvs;
    logic [DIVISOR_W-1:0]  partial;
    logic [DIVIDEND_W-1:0] quo_work;
    logic                  zero;

    logic [PART_W-1:0]     shifted;
    logic [PART_W-1:0]     diff;
    logic                  ge;
    logic [DIVISOR_W-1:0]  part_next;
    logic [DIVIDEND_W-1:0] quo_next;
    logic                  round_up;
    logic [DIVIDEND_W-1:0] quo_final;
    logic                  last_iter;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = CALC;
            CALC:    if (last_iter) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // One restoring iteration: shift in next dividend bit, trial-subtract divisor
    always_comb begin
        last_iter = (cnt == CNT_W'(1));
        shifted   = {partial, dvd[DIVIDEND_W-1]};
        diff      = shifted - {1'b0, dvs};
        ge        = (shifted >= {1'b0, dvs});
        part_next = ge ? diff[DIVISOR_W-1:0] : shifted[DIVISOR_W-1:0];
        quo_next  = {quo_work[DIVIDEND_W-2:0], ge};
`ifdef DIV_ROUND_EN
        // 2*r >= d rounds half up; q = 255 forces d = 1, r = 0, so no overflow
        round_up  = ({part_next, 1'b0} >= {1'b0, dvs});
`else
        round_up  = 1'b0;
`endif
        quo_final = quo_next + DIVIDEND_W'(round_up);
    end

    // Operand capture, iteration registers and held result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            dvd         <= '0;
            dvs         <= '0;
            partial     <= '0;
            quo_work    <= '0;
            zero        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd      <= dividend;
                        dvs      <= divisor;
                        partial  <= '0;
                        quo_work <= '0;
                        zero     <= (divisor == '0);
                        cnt      <= (divisor == '0) ? CNT_W'(1) : CNT_W'(DIVIDEND_W);
                    end
                end
                CALC: begin
                    cnt      <= cnt - CNT_W'(1);
                    dvd      <= {dvd[DIVIDEND_W-2:0], 1'b0};
                    partial  <= part_next;
                    quo_work <= quo_next;
                    if (last_iter) begin
                        if (zero) begin
                            quotient    <= '1;
                            remainder   <= dvd[DIVISOR_W-1:0];
                            div_by_zero <= 1'b1;
                        end else begin
                            quotient    <= quo_final;
                            remainder   <= part_next;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_approx_div_8x4.sv
// Scoreboard bench for approx_div_8x4: driver pushes expected results, monitor pops on handshake.
module tb_approx_div_8x4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    typedef struct packed {
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
    } exp_t;

    exp_t sb[$];
    int   tests;
    int   fails;

    approx_div_8x4 #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division, saturated result for zero divisor
    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int   q;
        int   r;
        if (b == 0) begin
            e.q  = 8'hFF;
            e.r  = 4'(a % 16);
            e.dz = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
`ifdef DIV_ROUND_EN
            if (2 * r >= b) q = q + 1;
`endif
            e.q  = 8'(q);
            e.r  = 4'(r);
            e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Monitor: compare each delivered result against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", 32'(quotient), 32'(e.q));
                check("remainder", 32'(remainder), 32'(e.r));
                check("div_by_zero", 32'(div_by_zero), 32'(e.dz));
            end
        end
    end

    // Issue one division, check latency, hold under backpressure, then release
    task automatic run_div(input int a, input int b, input int hold, input bit poke);
        exp_t e;
        int   k;
        k = 0;
        while (!in_ready && k < 30) begin
            @(posedge clk); #1; k++;
        end
        check("idle_ready", 32'(in_ready), 32'd1);
        e        = model(a, b);
        in_valid = 1'b1;
        dividend = 8'(a);
        divisor  = 4'(b);
        @(posedge clk);
        sb.push_back(e);
        #1;
        in_valid = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        check("busy_not_ready", 32'(in_ready), 32'd0);
        k = 0;
        while (!out_valid && k < 20) begin
            if (poke) begin
                in_valid = 1'b1;
                dividend = 8'($urandom);
                divisor  = 4'($urandom);
            end
            @(posedge clk); #1; k++;
        end
        in_valid = 1'b0;
        check("latency", 32'(k), (b == 0) ? 32'd1 : 32'd8);
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_quotient", 32'(quotient), 32'(e.q));
            check("hold_remainder", 32'(remainder), 32'(e.r));
            check("hold_no_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("back_to_idle", 32'(in_ready), 32'd1);
        check("valid_dropped", 32'(out_valid), 32'd0);
    endtask

    initial begin
        bit seen;
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of CALC aborts the division
        in_valid = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        check("abort_no_result", 32'(seen), 32'd0);
        check("abort_quotient", 32'(quotient), 32'd0);

        // Directed cases
        run_div(225, 15, 5, 1'b1);
        run_div(200, 7, 1, 1'b0);
        run_div(255, 2, 0, 1'b1);
        run_div(255, 1, 2, 1'b0);
        run_div(100, 0, 5, 1'b1);
        run_div(0, 0, 0, 1'b0);
        run_div(0, 9, 0, 1'b0);
        run_div(14, 15, 0, 1'b0);

        // Every 4x4 product divided by its nonzero operand recovers the other operand
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_div(a * b, b, 0, 1'b0);
            end
        end

        // Random operands with random backpressure and CALC-time in_valid noise
        for (int i = 0; i < 60; i++) begin
            run_div(int'($urandom_range(255, 0)), int'($urandom_range(15, 0)),
                    int'($urandom_range(3, 0)), 1'($urandom));
        end

        repeat (2) @(posedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
